matrix_result_buffer: RTL
=========================

// Module: matrix_result_buffer
// PURPOSE
//  Downstream consumer of sequential_matrix_multiplier. Captures each (z_i,z_j,z_out) result strobe
//  into an M x M register array and acknowledges it with z_ack. On the multiplier's done pulse it
//  drains the finished matrix as a valid/ready stream, in row-major order, to the next stage
//  (host readback / DMA).
//  Upstream strobes every partial sum (once per k). The last write to each (i,j) is the final value.
// PARAMETERS
//  M   4   matrix dimension (square M x M)
//  DW  32  element width (IEEE-754 single bits, treated as opaque data)
//  IW  derived = max(1,$clog2(M))  index width; not user-overridable
// PORTS
//  clk         in   1   clock
//  rst         in   1   reset
//  z_out       in   DW  result data from multiplier
//  z_i         in   IW  result row index
//  z_j         in   IW  result column index
//  z_stb       in   1   result strobe (held high until z_ack seen)
//  z_ack       out  1   one-cycle acknowledge of z_stb
//  mul_done    in   1   one-cycle pulse: matrix complete
//  out_data    out  DW  drained element
//  out_i       out  IW  row of out_data
//  out_j       out  IW  column of out_data
//  out_last    out  1   high with element (M-1,M-1) (or last in drain order)
//  out_valid   out  1   stream valid
//  out_ready   in   1   stream ready
//  busy        out  1   high while in S_DRAIN
//  drain_done  out  1   one-cycle pulse after last element accepted
// BEHAVIOUR
//  - Reset (rst asynchronous, active-low; clock clk): state=S_COLLECT; z_ack=0, out_valid=0,
//    busy=0, drain_done=0, done_pend=0, drain counters=0, written mask=0. out_data/out_i/out_j/
//    out_last are 0. Reset mid-drain aborts the drain. Reset mid-collect discards all stored data.
//  - S_COLLECT: if z_stb && !z_ack then mem[z_i][z_j]<=z_out, wr_mask[z_i][z_j]<=1, z_ack<=1.
//    Otherwise z_ack<=0. So z_ack is a 1-cycle pulse, at most one write per strobe.
//    Re-writes to the same index overwrite.
//  - Indices >= M (possible when M is not a power of 2): write dropped. z_ack still pulsed
//    (no upstream deadlock).
//  - mul_done is latched into done_pend. Go to S_DRAIN when done_pend && !z_stb && !z_ack.
//    A coincident strobe is written first. Clear done_pend on entry.
//  - S_DRAIN: busy=1, out_valid=1 (registered, from the cycle after entry). out_data=mem[ri][rj],
//    out_i=ri, out_j=rj, out_last=(ri==M-1&&rj==M-1). Unwritten entries (wr_mask=0) output 0.
//    A transfer happens when out_valid&&out_ready. It advances rj, and wraps rj to 0 with ri+1.
//    Outputs are held stable while !out_ready.
//  - Last transfer: out_valid<=0, busy<=0, drain_done<=1 for 1 cycle, ri=rj=0, wr_mask<=0,
//    state<=S_COLLECT. Storage contents are retained.
//  - z_stb during S_DRAIN is not acked (upstream stalls) until return to S_COLLECT.
//  - mul_done during S_DRAIN sets done_pend, which gives a second drain afterwards.
//  - Latency: mul_done to first out_valid = 2 cycles if no strobe is pending. Drain takes M*M
//    cycles at full out_ready.
// CONFIGURATION
//  MRB_TRANSPOSE_EN defined: drain is column-major (rj outer, ri inner, out_last still on (M-1,M-1)).
//   out_i/out_j still report true indices.
//  Undefined: row-major drain as above.
// STRUCTURE
//  Package mm_pkg: state localparams S_COLLECT/S_DRAIN, function idx_w(M) (max(1,clog2)),
//   shared with sequential_matrix_multiplier for index width.
//  Sub-module mrb_storage: M*M x DW register array, 1 sync write port, 1 async read port,
//   per-entry written mask with synchronous clear.
//  The top holds the FSM, ack logic, done latch and drain counters.
// TESTING
//  1. Reset, then write (1,2)=0x3F800000 with z_stb held until ack -> z_ack high exactly 1 cycle,
//     mem[1][2]=0x3F800000.
//  2. Write (0,0)=0x40000000 then 0x40400000, then mul_done, out_ready=1 -> first drained element
//     is (0,0)=0x40400000, 16 beats, out_last on beat 16, drain_done 1 cycle after.
//  3. Full 4x4 fill via identity*A run, then drain with out_ready toggling 1/0 -> 16 beats in
//     row-major order, data stable during stalls.
//  4. Assert z_stb while busy -> z_ack stays 0 until drain_done+1, then write is accepted.
//  5. rst low at drain beat 5 -> out_valid=0, busy=0 immediately. Next mul_done drains 16 zeros.
//  6. MRB_TRANSPOSE_EN build: drain order (0,0),(1,0),(2,0),(3,0),(0,1)...; out_last at (3,3).

Source files
------------

// File: rtl/mm_pkg.sv
// Shared types and helpers for the matrix multiplier and its result buffer.
// Index width helper keeps both blocks agreeing on i/j bus widths.
package mm_pkg;

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_DRAIN   = 1'b1
    } state_t;

    function automatic int idx_w(input int m);
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/matrix_result_buffer_if.sv
// Result strobe, done pulse and drain stream between multiplier, buffer and host.
// master: multiplier/host side; slave: matrix_result_buffer.
interface matrix_result_buffer_if
    import mm_pkg::*;
#(
    parameter int M  = 4,
    parameter int DW = 32
);
    localparam int IW = idx_w(M);

    logic [DW-1:0] z_out;
    logic [IW-1:0] z_i;
    logic [IW-1:0] z_j;
    logic          z_stb;
    logic          z_ack;
    logic          mul_done;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_i;
    logic [IW-1:0] out_j;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          drain_done;

    modport master (
        output z_out, z_i, z_j, z_stb, mul_done, out_ready,
        input  z_ack, out_data, out_i, out_j, out_last,
        input  out_valid, busy, drain_done
    );

    modport slave (
        input  z_out, z_i, z_j, z_stb, mul_done, out_ready,
        output z_ack, out_data, out_i, out_j, out_last,
        output out_valid, busy, drain_done
    );

endinterface

// File: rtl/mrb_storage.sv
// M x M result register array: one sync write port, one async read port.
// Per-entry written mask makes never-written entries read back as zero.
module mrb_storage
    import mm_pkg::*;
#(
    parameter  int M  = 4,
    parameter  int DW = 32,
    localparam int IW = idx_w(M)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic          clr,
    input  logic [IW-1:0] wi,
    input  logic [IW-1:0] wj,
    input  logic [DW-1:0] wd,
    input  logic [IW-1:0] ri,
    input  logic [IW-1:0] rj,
    output logic [DW-1:0] rd
);
    localparam logic [IW:0] MV = (IW+1)'(M);

    logic [DW-1:0]         mem [M][M];
    logic [M-1:0][M-1:0]   mask;
    logic                  wr_ok;
    logic                  rd_ok;

    // Out-of-range indices only exist when M is not a power of two
    assign wr_ok = we && ({1'b0, wi} < MV) && ({1'b0, wj} < MV);
    assign rd_ok = ({1'b0, ri} < MV) && ({1'b0, rj} < MV);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wi][wj] <= wd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask <= '0;
        end else if (clr) begin
            mask <= '0;
        end else if (wr_ok) begin
            mask[wi][wj] <= 1'b1;
        end
    end

    assign rd = (rd_ok && mask[ri][rj]) ? mem[ri][rj] : '0;

endmodule

// File: rtl/matrix_result_buffer.sv
// Collects multiplier results into an M x M array and drains them as a stream.
// MRB_TRANSPOSE_EN: drain column-major instead of row-major.
module matrix_result_buffer
    import mm_pkg::*;
#(
    parameter int M  = 4,
    parameter int DW = 32
) (
    input logic                   clk,
    input logic                   rst,
    matrix_result_buffer_if.slave bus
);
    localparam int          IW   = idx_w(M);
    localparam logic [IW-1:0] LAST = IW'(M - 1);

    state_t        state;
    logic          done_pend;
    logic          z_ack;
    logic          out_valid;
    logic          out_last;
    logic          busy;
    logic          drain_done;
    logic [DW-1:0] out_data;
    logic [IW-1:0] ri;
    logic [IW-1:0] rj;
    logic [IW-1:0] nxt_i;
    logic [IW-1:0] nxt_j;
    logic [IW-1:0] rd_i;
    logic [IW-1:0] rd_j;
    logic [DW-1:0] rd_data;
    logic          we;
    logic          clr;
    logic          xfer;
    logic          at_last;

    assign we      = (state == S_COLLECT) && bus.z_stb && !z_ack;
    assign xfer    = out_valid && bus.out_ready;
    assign at_last = (ri == LAST) && (rj == LAST);
    assign clr     = (state == S_DRAIN) && xfer && at_last;

    always_comb begin
        nxt_i = ri;
        nxt_j = rj;
`ifdef MRB_TRANSPOSE_EN
        if (ri == LAST) begin
            nxt_i = '0;
            nxt_j = rj + 1'b1;
        end else begin
            nxt_i = ri + 1'b1;
        end
`else
        if (rj == LAST) begin
            nxt_j = '0;
            nxt_i = ri + 1'b1;
        end else begin
            nxt_j = rj + 1'b1;
        end
`endif
    end

    // Read port looks one beat ahead so out_data can be registered
    assign rd_i = (state == S_DRAIN) ? nxt_i : '0;
    assign rd_j = (state == S_DRAIN) ? nxt_j : '0;

    mrb_storage #(.M(M), .DW(DW)) u_storage (
        .clk (clk),
        .rst (rst),
        .we  (we),
        .clr (clr),
        .wi  (bus.z_i),
        .wj  (bus.z_j),
        .wd  (bus.z_out),
        .ri  (rd_i),
        .rj  (rd_j),
        .rd  (rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_COLLECT;
            done_pend  <= 1'b0;
            z_ack      <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            drain_done <= 1'b0;
            out_data   <= '0;
            ri         <= '0;
            rj         <= '0;
        end else begin
            drain_done <= 1'b0;
            unique case (state)
                S_COLLECT: begin
                    z_ack <= we;
                    if (done_pend && !bus.z_stb && !z_ack) begin
                        state     <= S_DRAIN;
                        done_pend <= bus.mul_done;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        out_data  <= rd_data;
                        out_last  <= (M == 1);
                        ri        <= '0;
                        rj        <= '0;
                    end else if (bus.mul_done) begin
                        done_pend <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    z_ack <= 1'b0;
                    if (bus.mul_done) begin
                        done_pend <= 1'b1;
                    end
                    if (xfer && at_last) begin
                        state      <= S_COLLECT;
                        out_valid  <= 1'b0;
                        busy       <= 1'b0;
                        drain_done <= 1'b1;
                        out_last   <= 1'b0;
                        out_data   <= '0;
                        ri         <= '0;
                        rj         <= '0;
                    end else if (xfer) begin
                        ri       <= nxt_i;
                        rj       <= nxt_j;
                        out_data <= rd_data;
                        out_last <= (nxt_i == LAST) && (nxt_j == LAST);
                    end
                end
                default: state <= S_COLLECT;
            endcase
        end
    end

    assign bus.z_ack      = z_ack;
    assign bus.out_valid  = out_valid;
    assign bus.out_last   = out_last;
    assign bus.busy       = busy;
    assign bus.drain_done = drain_done;
    assign bus.out_data   = out_data;
    assign bus.out_i      = ri;
    assign bus.out_j      = rj;

endmodule
